// File: rtl/wrr_pkt_arbiter_if.sv
// Handshake bundle between per-queue request logic (master) and the
// packet-granular WRR arbiter (slave).
interface wrr_pkt_arbiter_if #(
  parameter int ARB_NUM = 8,
  parameter int WW      = 4
);
  logic [ARB_NUM-1:0]    req;
  logic                  done;
  logic [ARB_NUM*WW-1:0] weight;
  logic                  weight_load;
  logic [ARB_NUM-1:0]    gnt;
  logic                  gnt_vld;
  logic                  refresh;

  modport master (
    output req, done, weight, weight_load,
    input  gnt, gnt_vld, refresh
  );

  modport slave (
    input  req, done, weight, weight_load,
    output gnt, gnt_vld, refresh
  );
endinterface

// File: rtl/wrr_pkt_arbiter.sv
// Packet-granular weighted round-robin arbiter.
// Per-channel credit counters gate requests; a rotating pointer picks the
// winner; the grant is held until the read engine pulses done. Weight 0
// disables a channel. Credits are refreshed only when every requester with a
// non-zero weight has run out of credit.
// Optional build macro: WRR_WORK_CONSERVING_EN -- when defined, the refresh
// cycle also arbitrates (using init in place of credit), so there is no bubble.
module wrr_pkt_arbiter #(
  parameter int ARB_NUM    = 8,
  parameter int WEIGHT_MAX = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  wrr_pkt_arbiter_if.slave bus
);
  localparam int WW = $clog2(WEIGHT_MAX) + 1;
  localparam int PW = (ARB_NUM > 1) ? $clog2(ARB_NUM) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_reg, state_next;
  logic [PW-1:0]      ptr_reg, ptr_next;
  logic [PW-1:0]      gnt_idx_reg, gnt_idx_next;
  logic [ARB_NUM-1:0] gnt_reg, gnt_next;
  logic               refresh_reg, refresh_next;

  logic [WW-1:0]      init_reg   [ARB_NUM];
  logic [WW-1:0]      credit_reg [ARB_NUM];

  logic [ARB_NUM-1:0] eligible;   // requesting and still holding credit
  logic [ARB_NUM-1:0] weighted;   // requesting and not disabled by weight 0
  logic [ARB_NUM-1:0] arb_set;    // set the round-robin search runs over
  logic               starved;
  logic               win_found;
  logic [PW-1:0]      win_idx;
  logic [PW:0]        sum_tmp;
  logic [PW-1:0]      cand;
  logic               do_refresh;
  logic               do_dec;

  // Per-channel request qualification
  for (genvar gi = 0; gi < ARB_NUM; gi++) begin : g_chan
    assign eligible[gi] = bus.req[gi] & (credit_reg[gi] != '0);
    assign weighted[gi] = bus.req[gi] & (init_reg[gi] != '0);
  end

  assign starved = (eligible == '0) & (|weighted);

  // Round-robin search: first member of arb_set at or after the pointer
  always_comb begin
    arb_set = eligible;
`ifdef WRR_WORK_CONSERVING_EN
    if (eligible == '0) arb_set = weighted;
`endif
    win_found = 1'b0;
    win_idx   = '0;
    sum_tmp   = '0;
    cand      = '0;
    for (int k = 0; k < ARB_NUM; k++) begin
      sum_tmp = {1'b0, ptr_reg} + (PW+1)'(k);
      if (sum_tmp >= (PW+1)'(ARB_NUM)) sum_tmp = sum_tmp - (PW+1)'(ARB_NUM);
      cand = sum_tmp[PW-1:0];
      if (!win_found && arb_set[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // FSM next-state and registered-output decode
  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    gnt_idx_next = gnt_idx_reg;
    gnt_next     = gnt_reg;
    refresh_next = 1'b0;
    do_refresh   = 1'b0;
    do_dec       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (starved) begin
          // a coincident weight load supersedes the refresh
          do_refresh   = ~bus.weight_load;
          refresh_next = ~bus.weight_load;
`ifdef WRR_WORK_CONSERVING_EN
          if (win_found) begin
            gnt_next          = '0;
            gnt_next[win_idx] = 1'b1;
            gnt_idx_next      = win_idx;
            state_next        = BUSY;
          end
`endif
        end else if (win_found) begin
          gnt_next          = '0;
          gnt_next[win_idx] = 1'b1;
          gnt_idx_next      = win_idx;
          state_next        = BUSY;
        end
      end
      BUSY: begin
        if (bus.done) begin
          do_dec     = 1'b1;
          ptr_next   = (gnt_idx_reg == PW'(ARB_NUM - 1)) ? '0 : gnt_idx_reg + PW'(1);
          gnt_next   = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM, pointer and grant registers
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      gnt_idx_reg <= '0;
      gnt_reg     <= '0;
      refresh_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      gnt_idx_reg <= gnt_idx_next;
      gnt_reg     <= gnt_next;
      refresh_reg <= refresh_next;
    end
  end

  // Weight and credit registers: load beats refresh beats decrement
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < ARB_NUM; i++) begin
        init_reg[i]   <= '1;
        credit_reg[i] <= '1;
      end
    end else begin
      for (int i = 0; i < ARB_NUM; i++) begin
        if (bus.weight_load) begin
          init_reg[i]   <= bus.weight[(ARB_NUM-1-i)*WW +: WW];
          credit_reg[i] <= bus.weight[(ARB_NUM-1-i)*WW +: WW];
        end else if (do_refresh) begin
          credit_reg[i] <= init_reg[i];
        end else if (do_dec && (gnt_idx_reg == PW'(i)) && (credit_reg[i] != '0)) begin
          credit_reg[i] <= credit_reg[i] - WW'(1);
        end
      end
    end
  end

  assign bus.gnt     = gnt_reg;
  assign bus.gnt_vld = |gnt_reg;
  assign bus.refresh = refresh_reg;
endmodule

// File: tb/tb_wrr_pkt_arbiter.sv
// Bench for wrr_pkt_arbiter (ARB_NUM=4, WEIGHT_MAX=8 -> 4-bit weights).
// A packet-level model (credits, pointer, held grant) predicts the outputs
// every cycle; directed scenarios add hand-computed literal expectations,
// followed by a randomized phase.
module tb_wrr_pkt_arbiter;
  localparam int N  = 4;
  localparam int WW = 4;

  logic clk;
  logic rst_n;

  wrr_pkt_arbiter_if #(.ARB_NUM(N), .WW(WW)) bus ();

  wrr_pkt_arbiter #(.ARB_NUM(N), .WEIGHT_MAX(8)) dut (
    .iClk  (clk),
    .iRst_n(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // model state
  int m_init [N];
  int m_cred [N];
  int m_ptr;
  int m_g;
  bit m_busy;
  bit m_refresh;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_init[i] = 15;
      m_cred[i] = 15;
    end
    m_ptr = 0; m_g = 0; m_busy = 0; m_refresh = 0;
  endtask

  // first channel in set, searching circularly from the pointer
  function automatic int pick(input bit [N-1:0] set);
    for (int k = 0; k < N; k++)
      if (set[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_step();
    int wv [N];
    bit [N-1:0] elig, wgt;
    int win;
    for (int i = 0; i < N; i++) begin
      wv[i]   = int'((bus.weight >> ((N-1-i)*WW)) & 16'hF);
      elig[i] = bus.req[i] && (m_cred[i] > 0);
      wgt[i]  = bus.req[i] && (m_init[i] > 0);
    end
    m_refresh = 0;
    if (!m_busy) begin
      if (elig != 0) begin
        m_g = pick(elig); m_busy = 1;
      end else if (wgt != 0) begin
        if (!bus.weight_load) begin
          for (int i = 0; i < N; i++) m_cred[i] = m_init[i];
          m_refresh = 1;
        end
`ifdef WRR_WORK_CONSERVING_EN
        win = pick(wgt);
        m_g = win; m_busy = 1;
`endif
      end
    end else if (bus.done) begin
      if (!bus.weight_load && m_cred[m_g] > 0) m_cred[m_g]--;
      m_ptr  = (m_g + 1) % N;
      m_busy = 0;
    end
    if (bus.weight_load)
      for (int i = 0; i < N; i++) begin
        m_init[i] = wv[i];
        m_cred[i] = wv[i];
      end
  endtask

  task automatic compare();
    check("gnt", int'(bus.gnt), m_busy ? (1 << m_g) : 0);
    check("gnt_vld", int'(bus.gnt_vld), m_busy ? 1 : 0);
    check("refresh", int'(bus.refresh), m_refresh ? 1 : 0);
  endtask

  // one clock: model follows the edge, outputs checked at the falling edge
  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    @(negedge clk);
    compare();
  endtask

  function automatic int gidx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  int ref_cnt;
  int pkt_no = 0;

  // wait (bounded) for a grant, hold it, then pulse done
  task automatic do_packet(input int hold, output int idx);
    int n = 0;
    idx = -1;
    while (!bus.gnt_vld && n < 10) begin
      cyc(); n++;
      if (bus.refresh) ref_cnt++;
    end
    check("grant_wait", int'(bus.gnt_vld), 1);
    if (!bus.gnt_vld) return;
    idx = gidx(bus.gnt);
    pkt_no++;
    $display("pkt %0d granted ch%0d", pkt_no, idx);
    repeat (hold) cyc();
    bus.done = 1'b1; cyc(); bus.done = 1'b0;
  endtask

  task automatic wait_grant();
    int n = 0;
    while (!bus.gnt_vld && n < 10) begin cyc(); n++; end
    check("grant_wait", int'(bus.gnt_vld), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int cnt [N];
    int vld_cnt;

    rst_n = 1'b0;
    bus.req = '0; bus.done = 1'b0; bus.weight = '0; bus.weight_load = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_gnt", int'(bus.gnt), 0);
    check("rst_gnt_vld", int'(bus.gnt_vld), 0);
    check("rst_refresh", int'(bus.refresh), 0);
    cyc();
    rst_n = 1'b1;

    // default weights (15 each): strict rotation, one refresh after 60 packets
    bus.req = 4'b1111;
    ref_cnt = 0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int k = 0; k < 64; k++) begin
      do_packet(1, idx);
      check("rr_order", idx, k % N);
      if (idx >= 0) cnt[idx]++;
    end
    for (int i = 0; i < N; i++) check("rr_count", cnt[i], 16);
    check("rr_refreshes", ref_cnt, 1);

    // weights {3,1,2,0}: per round ch0 x3, ch1 x1, ch2 x2, ch3 never
    bus.req = '0;
    bus.weight = {4'd3, 4'd1, 4'd2, 4'd0};
    bus.weight_load = 1'b1; cyc(); bus.weight_load = 1'b0;
    bus.req = 4'b1111;
    ref_cnt = 0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int k = 0; k < 18; k++) begin
      do_packet(2, idx);
      if (idx >= 0) cnt[idx]++;
    end
    check("wrr_ch0", cnt[0], 9);
    check("wrr_ch1", cnt[1], 3);
    check("wrr_ch2", cnt[2], 6);
    check("wrr_ch3", cnt[3], 0);
    check("wrr_refreshes", ref_cnt, 2);

    // only the weight-0 channel requests: no grant, no refresh
    bus.req = 4'b1000;
    vld_cnt = 0; ref_cnt = 0;
    repeat (20) begin
      cyc();
      if (bus.gnt_vld) vld_cnt++;
      if (bus.refresh) ref_cnt++;
    end
    check("w0_grants", vld_cnt, 0);
    check("w0_refreshes", ref_cnt, 0);

    // grant held on ch1 while its request drops; only done releases it
    bus.req = '0;
    bus.weight = {4'd2, 4'd2, 4'd2, 4'd2};
    bus.weight_load = 1'b1; cyc(); bus.weight_load = 1'b0;
    bus.req = 4'b0010;
    wait_grant();
    check("hold_gnt", int'(bus.gnt), 4'b0010);
    bus.req = '0;
    repeat (5) begin
      cyc();
      check("hold_gnt", int'(bus.gnt), 4'b0010);
    end
    bus.done = 1'b1; cyc(); bus.done = 1'b0;
    check("release_gnt", int'(bus.gnt), 0);

    // load and done together on ch0 (credit 2): load wins, pointer moves to 1
    bus.req = 4'b0001;
    wait_grant();
    check("ld_done_gnt0", int'(bus.gnt), 4'b0001);
    bus.req = 4'b1111;
    bus.weight = {4'd5, 4'd5, 4'd5, 4'd5};
    bus.weight_load = 1'b1; bus.done = 1'b1;
    cyc();
    bus.weight_load = 1'b0; bus.done = 1'b0;
    wait_grant();
    check("ld_done_next", int'(bus.gnt), 4'b0010);
    bus.done = 1'b1; cyc(); bus.done = 1'b0;

    // exhaust credits with iReq=0011, then observe the refresh timing
    bus.req = '0;
    bus.weight = {4'd1, 4'd1, 4'd1, 4'd1};
    bus.weight_load = 1'b1; cyc(); bus.weight_load = 1'b0;
    bus.req = 4'b0011;
    do_packet(1, idx);
    check("exh_first", idx, 0);
    do_packet(1, idx);
    check("exh_second", idx, 1);
    cyc();
    check("exh_refresh", int'(bus.refresh), 1);
`ifdef WRR_WORK_CONSERVING_EN
    check("exh_gnt_same", int'(bus.gnt), 4'b0001);
`else
    check("exh_bubble", int'(bus.gnt), 0);
    cyc();
    check("exh_refresh_end", int'(bus.refresh), 0);
    check("exh_gnt_next", int'(bus.gnt), 4'b0001);
`endif
    bus.done = 1'b1; cyc(); bus.done = 1'b0;
    bus.req = '0;
    cyc();

    // asynchronous reset mid-packet drops the grant at once
    bus.req = 4'b1111;
    wait_grant();
    #2 rst_n = 1'b0;
    #1;
    check("async_gnt", int'(bus.gnt), 0);
    check("async_gnt_vld", int'(bus.gnt_vld), 0);
    model_reset();
    @(negedge clk);
    cyc();
    rst_n = 1'b1;
    wait_grant();
    check("post_rst_gnt", int'(bus.gnt), 4'b0001);
    bus.done = 1'b1; cyc(); bus.done = 1'b0;

    // randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0) bus.req[i] = ~bus.req[i];
      bus.done = m_busy ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
      bus.weight_load = ($urandom_range(63) == 0);
      for (int i = 0; i < N; i++)
        bus.weight[(N-1-i)*WW +: WW] = 4'($urandom_range(8));
      cyc();
    end
    bus.done = 1'b0; bus.weight_load = 1'b0; bus.req = '0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
